// File: rtl/pc_seq_pkg.sv
// Shared state encoding for the PC sequencer FSM.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_IN  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

endpackage

// File: rtl/pc_sequencer_button.sv
// button_conditioner: 2-FF synchronizer, optional debounce (PC_SEQ_DEBOUNCE_EN),
// and a falling-edge detector producing a one-cycle press event.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic press_evt
);

    logic r_sync1, r_sync2, r_lvl_prev, r_evt;
    logic w_lvl;

`ifdef PC_SEQ_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DW-1:0] r_cnt;
    logic          r_deb;

    // Level flips only after the synchronized input disagrees for a full window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_deb <= 1'b1;
        end else if (r_sync2 == r_deb) begin
            r_cnt <= '0;
        end else if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_lvl = r_deb;
`else
    assign w_lvl = r_sync2;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_lvl_prev <= 1'b1;
            r_evt      <= 1'b0;
        end else begin
            r_sync1    <= button;
            r_sync2    <= r_sync1;
            r_lvl_prev <= w_lvl;
            r_evt      <= r_lvl_prev & ~w_lvl;
        end
    end

    assign press_evt = r_evt;

endmodule

// File: rtl/pc_sequencer.sv
// PC action sequencer: run/halt/input-wait/memory-stall FSM plus retired counter.
// Optional button debounce enabled by defining PC_SEQ_DEBOUNCE_EN.
module pc_sequencer #(
    parameter int MEM_WAIT        = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button,
    input  logic             op_halt,
    input  logic             op_jump,
    input  logic             op_branch,
    input  logic             alu_cond,
    input  logic             op_in,
    input  logic             op_mem,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             pc_clear,
    output logic             jal_save,
    output logic             input_latch,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retired
);
    import pc_seq_pkg::*;

    localparam int SW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    state_t          r_state, w_next;
    logic [SW-1:0]   r_stall, w_stall_next;
    logic [CNT_W-1:0] r_retired;
    logic            w_evt;
    logic            w_inc, w_load, w_clear, w_jal, w_latch;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk       (clk),
        .reset     (reset),
        .button    (button),
        .press_evt (w_evt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_stall   <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_stall <= w_stall_next;
            if ((w_inc || w_load) && (r_retired != {CNT_W{1'b1}}))
                r_retired <= r_retired + 1'b1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_stall_next = r_stall;
        w_inc        = 1'b0;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        w_jal        = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (op_halt) begin
                    w_next = ST_HALTED;
                end else if (op_jump) begin
                    w_load = 1'b1;
                    w_jal  = 1'b1;
                end else if (op_branch && alu_cond) begin
                    w_load = 1'b1;
                end else if (op_in) begin
                    w_next = ST_WAIT_IN;
                end else if (op_mem && (MEM_WAIT > 0)) begin
                    w_stall_next = SW'(MEM_WAIT - 1);
                    w_next       = ST_MEM_WAIT;
                end else begin
                    w_inc = 1'b1;
                end
            end
            ST_WAIT_IN: begin
                if (w_evt) begin
                    w_latch = 1'b1;
                    w_inc   = 1'b1;
                    w_next  = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (r_stall != '0) begin
                    w_stall_next = r_stall - 1'b1;
                end else begin
                    w_inc  = 1'b1;
                    w_next = ST_RUN;
                end
            end
            default: begin
                if (w_evt) begin
                    w_clear = 1'b1;
                    w_next  = ST_RUN;
                end
            end
        endcase
        // Reset silences every strobe in the cycle it is asserted.
        if (reset) begin
            w_inc   = 1'b0;
            w_load  = 1'b0;
            w_clear = 1'b0;
            w_jal   = 1'b0;
            w_latch = 1'b0;
        end
    end

    assign pc_inc      = w_inc;
    assign pc_load     = w_load;
    assign pc_clear    = w_clear;
    assign jal_save    = w_jal;
    assign input_latch = w_latch;
    assign halted      = (r_state == ST_HALTED);
    assign state       = r_state;
    assign retired     = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against a behavioural model.
module tb_pc_sequencer;

    localparam int MEM_WAIT = 2;
    localparam int DEB      = 16;
    localparam int CNT_W    = 5;
    localparam int RET_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1, button = 1'b1;
    logic op_halt = 0, op_jump = 0, op_branch = 0, alu_cond = 0, op_in = 0, op_mem = 0;
    logic pc_inc, pc_load, pc_clear, jal_save, input_latch, halted;
    logic [1:0] state;
    logic [CNT_W-1:0] retired;

    int n_vec = 0, n_err = 0;

    pc_sequencer #(.MEM_WAIT(MEM_WAIT), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .button(button),
        .op_halt(op_halt), .op_jump(op_jump), .op_branch(op_branch), .alu_cond(alu_cond),
        .op_in(op_in), .op_mem(op_mem),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_clear(pc_clear), .jal_save(jal_save),
        .input_latch(input_latch), .halted(halted), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // Observed bundle: {halted, state, retired, inc, load, clear, jal, latch}
    wire [CNT_W+7:0] w_obs = {halted, state, retired, pc_inc, pc_load, pc_clear, jal_save, input_latch};

    // ---------------- behavioural model ----------------
    int   m_mode, m_stall, m_ret, m_run;
    logic m_evt, m_lvl, m_lvl_d;
    logic [2:0] raw_hist;   // raw button samples taken 1, 2 and 3 edges ago

    function automatic logic [4:0] model_strb();   // {inc, load, clear, jal, latch}
        if (reset) return 5'b0;
        case (m_mode)
            0: begin
                if (op_halt)                       return 5'b00000;
                if (op_jump)                       return 5'b01010;
                if (op_branch && alu_cond)         return 5'b01000;
                if (op_in)                         return 5'b00000;
                if (op_mem && MEM_WAIT > 0)        return 5'b00000;
                return 5'b10000;
            end
            1:       return m_evt ? 5'b10001 : 5'b00000;
            2:       return (m_stall == 0) ? 5'b10000 : 5'b00000;
            default: return m_evt ? 5'b00100 : 5'b00000;
        endcase
    endfunction

    function automatic logic [CNT_W+7:0] model_all();
        return {(m_mode == 3), 2'(m_mode), CNT_W'(m_ret), model_strb()};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode <= 0; m_stall <= 0; m_ret <= 0; m_run <= 0;
            m_evt <= 1'b0; m_lvl <= 1'b1; m_lvl_d <= 1'b1; raw_hist <= 3'b111;
        end else begin
            if ((model_strb() & 5'b11000) != 5'b0 && m_ret < RET_MAX) m_ret <= m_ret + 1;
            case (m_mode)
                0: begin
                    if (op_halt) m_mode <= 3;
                    else if (op_jump || (op_branch && alu_cond)) m_mode <= 0;
                    else if (op_in) m_mode <= 1;
                    else if (op_mem && MEM_WAIT > 0) begin m_mode <= 2; m_stall <= MEM_WAIT - 1; end
                end
                1:       if (m_evt) m_mode <= 0;
                2:       if (m_stall == 0) m_mode <= 0; else m_stall <= m_stall - 1;
                default: if (m_evt) m_mode <= 0;
            endcase
            raw_hist <= {raw_hist[1:0], button};
`ifdef PC_SEQ_DEBOUNCE_EN
            // press seen when the debounced level (synced sample stable DEB times) goes 1->0
            if (raw_hist[1] == m_lvl) m_run <= 0;
            else if (m_run == DEB - 1) begin m_lvl <= raw_hist[1]; m_run <= 0; end
            else m_run <= m_run + 1;
            m_lvl_d <= m_lvl;
            m_evt   <= m_lvl_d & ~m_lvl;
`else
            // press seen three edges after the first low sample
            m_evt <= raw_hist[2] & ~raw_hist[1];
`endif
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clr_ops();
        op_halt = 0; op_jump = 0; op_branch = 0; alu_cond = 0; op_in = 0; op_mem = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1; button = 1; clr_ops();
        tick(); tick(); #1;
        n_vec++;
        if (w_obs !== {1'b0, 2'd0, {CNT_W{1'b0}}, 5'b0}) begin
            n_err++; $display("FAIL reset_state: got %h want %h", w_obs, {1'b0, 2'd0, {CNT_W{1'b0}}, 5'b0});
        end
        reset = 0;
        tick();
    endtask

    task automatic test_run_inc();
        reset = 1; tick(); reset = 0;
        for (int i = 0; i < 5; i++) begin
            #1; n_vec++;
            if (w_obs !== model_all() || pc_inc !== 1'b1) begin
                n_err++; $display("FAIL run_inc[%0d]: got %h want %h", i, w_obs, model_all());
            end
            tick();
        end
        n_vec++;
        if (retired !== CNT_W'(5) || state !== 2'd0) begin
            n_err++; $display("FAIL run_retired5: got ret=%0d st=%0d want ret=5 st=0", retired, state);
        end
    endtask

    task automatic test_jump_branch();
        op_jump = 1; #1; n_vec++;
        if ({pc_load, jal_save, pc_inc} !== 3'b110) begin
            n_err++; $display("FAIL jump: got load/jal/inc=%b want 110", {pc_load, jal_save, pc_inc});
        end
        tick(); clr_ops(); op_branch = 1; alu_cond = 0; #1; n_vec++;
        if ({pc_load, pc_inc} !== 2'b01) begin
            n_err++; $display("FAIL branch_nt: got load/inc=%b want 01", {pc_load, pc_inc});
        end
        tick(); alu_cond = 1; #1; n_vec++;
        if ({pc_load, jal_save, pc_inc} !== 3'b100) begin
            n_err++; $display("FAIL branch_t: got load/jal/inc=%b want 100", {pc_load, jal_save, pc_inc});
        end
        tick(); clr_ops();
    endtask

    task automatic test_wait_in();
        int n_lat = 0;
        op_in = 1; tick(); clr_ops();
        for (int i = 0; i < 20; i++) begin
            #1; n_vec++;
            if (w_obs !== model_all() || state !== 2'd1 || {pc_inc, pc_load, pc_clear, input_latch} !== 4'b0) begin
                n_err++; $display("FAIL wait_idle[%0d]: got %h want %h", i, w_obs, model_all());
            end
            tick();
        end
        button = 0;
        for (int i = 0; i < 110; i++) begin
            #1; n_vec++;
            if (w_obs !== model_all()) begin
                n_err++; $display("FAIL wait_press[%0d]: got %h want %h", i, w_obs, model_all());
            end
            if (input_latch === 1'b1) n_lat++;
            tick();
        end
        n_vec++;
        if (n_lat !== 1 || state !== 2'd0) begin
            n_err++; $display("FAIL wait_one_event: got latches=%0d st=%0d want 1 and 0", n_lat, state);
        end
        button = 1;
        repeat (40) tick();
    endtask

    task automatic test_mem();
        op_mem = 1;
        for (int i = 0; i < 3; i++) begin
            #1; n_vec++;
            if (pc_inc !== (i == 2) || state !== ((i == 0) ? 2'd0 : 2'd2) || w_obs !== model_all()) begin
                n_err++; $display("FAIL mem[%0d]: got inc=%b st=%0d want inc=%b", i, pc_inc, state, (i == 2));
            end
            tick(); clr_ops();
        end
        n_vec++;
        if (state !== 2'd0) begin
            n_err++; $display("FAIL mem_done: got st=%0d want 0", state);
        end
    endtask

    task automatic test_halt();
        int frozen, n_clr = 0;
        op_halt = 1; tick(); clr_ops();
        frozen = m_ret;
        for (int i = 0; i < 10; i++) begin
            op_jump = 1'($urandom); op_in = 1'($urandom); op_mem = 1'($urandom);
            #1; n_vec++;
            if (halted !== 1'b1 || state !== 2'd3 || retired !== CNT_W'(frozen) || w_obs !== model_all()) begin
                n_err++; $display("FAIL halt_hold[%0d]: got %h want %h", i, w_obs, model_all());
            end
            tick();
        end
        clr_ops(); button = 0;
        for (int i = 0; i < 40; i++) begin
            #1; n_vec++;
            if (w_obs !== model_all()) begin
                n_err++; $display("FAIL halt_press[%0d]: got %h want %h", i, w_obs, model_all());
            end
            if (pc_clear === 1'b1) n_clr++;
            tick();
            if (n_clr == 1 && i < 39) begin
                n_vec++;
                if (halted !== 1'b0 || state !== 2'd0 || retired !== CNT_W'(frozen)) begin
                    n_err++; $display("FAIL halt_restart: got h=%b st=%0d ret=%0d want 0 0 %0d", halted, state, retired, frozen);
                end
                n_clr++;
            end
        end
        n_vec++;
        if (n_clr !== 2) begin
            n_err++; $display("FAIL halt_one_clear: got clear events=%0d want 1", n_clr / 2 + n_clr % 2 * 0);
        end
        button = 1;
        repeat (40) tick();
    endtask

    task automatic test_saturate();
        repeat (RET_MAX + 5) tick();
        #1; n_vec++;
        if (retired !== CNT_W'(RET_MAX) || pc_inc !== 1'b1) begin
            n_err++; $display("FAIL saturate: got ret=%0d inc=%b want %0d 1", retired, pc_inc, RET_MAX);
        end
        tick();
    endtask

    task automatic test_reset_wait_in();
        int n_lat = 0;
        op_in = 1; tick(); clr_ops();
        button = 0; reset = 1; #1; n_vec++;
        if ({pc_inc, pc_load, pc_clear, jal_save, input_latch} !== 5'b0) begin
            n_err++; $display("FAIL rst_same_cycle: got strobes=%b want 00000", {pc_inc, pc_load, pc_clear, jal_save, input_latch});
        end
        tick(); #1; n_vec++;
        if (state !== 2'd0 || {pc_inc, pc_load, pc_clear, jal_save, input_latch} !== 5'b0 || retired !== '0) begin
            n_err++; $display("FAIL rst_wait_in: got st=%0d strobes=%b ret=%0d want 0", state,
                              {pc_inc, pc_load, pc_clear, jal_save, input_latch}, retired);
        end
        tick(); reset = 0;
        repeat (40) tick();
        op_in = 1; tick(); clr_ops();
        for (int i = 0; i < 30; i++) begin
            #1; if (input_latch === 1'b1) n_lat++;
            tick();
        end
        n_vec++;
        if (n_lat !== 0 || state !== 2'd1) begin
            n_err++; $display("FAIL rst_no_event: got latches=%0d st=%0d want 0 1", n_lat, state);
        end
        button = 1;
        repeat (40) tick();
        button = 0;
        for (int i = 0; i < 40; i++) begin
            #1; n_vec++;
            if (w_obs !== model_all()) begin
                n_err++; $display("FAIL rst_repress[%0d]: got %h want %h", i, w_obs, model_all());
            end
            if (input_latch === 1'b1) n_lat++;
            tick();
        end
        n_vec++;
        if (n_lat !== 1) begin
            n_err++; $display("FAIL rst_repress_event: got latches=%0d want 1", n_lat);
        end
        button = 1;
        repeat (40) tick();
    endtask

    task automatic test_random();
        int hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                button = ~button;
                hold = $urandom_range(1, 45);
            end
            hold--;
            op_halt   = ($urandom_range(0, 15) == 0);
            op_jump   = ($urandom_range(0, 5) == 0);
            op_branch = 1'($urandom);
            alu_cond  = 1'($urandom);
            op_in     = ($urandom_range(0, 7) == 0);
            op_mem    = ($urandom_range(0, 3) == 0);
            #1; n_vec++;
            if (w_obs !== model_all() || ($countones({pc_inc, pc_load, pc_clear}) > 1)) begin
                n_err++; $display("FAIL random[%0d]: got %h want %h", i, w_obs, model_all());
            end
            tick();
        end
        clr_ops(); button = 1;
    endtask

    initial begin
        test_reset();
        test_run_inc();
        test_jump_branch();
        test_wait_in();
        test_mem();
        test_halt();
        test_saturate();
        test_reset_wait_in();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
